hazard_ctrl: RTL and testbench

Scoreboard-based hazard and flush controller for the decode/register-file stage. Tracks in-flight register writes per architectural register, stalls decode while a source operand is pending, flushes the IF/ID path after a taken jump, and drains the pipeline on request. Sits beside the decoder and is fed by the decode and writeback stages; its stall/flush outputs gate the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_ctrl_sb_counter.sv | 32 +++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard/flush controller.
// Optional feature macro used by hazard_ctrl: HAZARD_FWD_EN (writeback bypass).
package hazard_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_CNT_W    = 2;
  localparam int FLUSH_CNT_W  = 4;

  // Controller states
  typedef logic [1:0] state_t;
  localparam state_t S_RUN   = 2'd0;
  localparam state_t S_FLUSH = 2'd1;
  localparam state_t S_DRAIN = 2'd2;

  // Decode-side request bundle
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 use_rs1;
    logic                 use_rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
  } dec_req_t;

  // Writeback-side commit bundle
  typedef struct packed {
    logic                 we;
    logic [REG_IDX_W-1:0] rd;
  } wb_req_t;

endpackage

// File: rtl/hazard_ctrl_sb_counter.sv
// Per-register in-flight write counter. inc+dec together cancel; a dec at
// zero is refused and flagged as underflow; an inc at full is refused.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full,
  output logic             underflow
);

  logic dec_ok, up, dn;

  assign zero      = (cnt == '0);
  assign full      = &cnt;
  assign underflow = dec & zero;
  assign dec_ok    = dec & ~zero;
  assign up        = inc & ~dec_ok & ~full;
  assign dn        = dec_ok & ~inc;

  // Count update; a cancelled inc/dec pair leaves the count alone
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (up)  cnt <= cnt + 1'b1;
    else if (dn)  cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard hazard / flush / drain controller for the decode stage.
// Define HAZARD_FWD_EN to let a same-cycle writeback of the last pending
// write satisfy a source operand (bypass) instead of stalling.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid_i,
  input  logic [REG_IDX_W-1:0] dec_rs1_i,
  input  logic [REG_IDX_W-1:0] dec_rs2_i,
  input  logic                 dec_use_rs1_i,
  input  logic                 dec_use_rs2_i,
  input  logic [REG_IDX_W-1:0] dec_rd_i,
  input  logic                 dec_reg_write_i,
  input  logic                 jump_i,
  input  logic                 drain_req_i,
  input  logic                 wb_reg_write_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  output logic                 stall_o,
  output logic                 issue_o,
  output logic                 flush_o,
  output logic                 drain_done_o,
  output logic [NUM_REGS-1:0]  busy_mask_o,
  output logic                 wb_err_o,
  output logic                 fwd_rs1_o,
  output logic                 fwd_rs2_o
);

  dec_req_t d;
  wb_req_t  w;

  assign d = '{valid: dec_valid_i, rs1: dec_rs1_i, rs2: dec_rs2_i,
               use_rs1: dec_use_rs1_i, use_rs2: dec_use_rs2_i,
               rd: dec_rd_i, reg_write: dec_reg_write_i};
  assign w = '{we: wb_reg_write_i, rd: wb_rd_i};

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            zero_v, full_v, unf_v;
  logic [NUM_REGS-1:1]            inc_v, dec_v;

  // x0 is never tracked: constant empty slot
  assign cnt[0]    = '0;
  assign zero_v[0] = 1'b1;
  assign full_v[0] = 1'b0;
  assign unf_v[0]  = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_sb
      assign inc_v[r] = issue_o & d.reg_write & (d.rd == REG_IDX_W'(r));
      assign dec_v[r] = w.we & (w.rd == REG_IDX_W'(r));
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc_v[r]),
        .dec       (dec_v[r]),
        .cnt       (cnt[r]),
        .zero      (zero_v[r]),
        .full      (full_v[r]),
        .underflow (unf_v[r])
      );
    end
  endgenerate

  state_t                 state;
  logic [FLUSH_CNT_W-1:0] fcnt;
  logic                   hit1, hit2, struct_hz, all_zero;

  // Bypass: writeback retiring the only pending write to a source
`ifdef HAZARD_FWD_EN
  assign fwd_rs1_o = w.we & (w.rd == d.rs1) & (cnt[d.rs1] == CNT_W'(1));
  assign fwd_rs2_o = w.we & (w.rd == d.rs2) & (cnt[d.rs2] == CNT_W'(1));
`else
  assign fwd_rs1_o = 1'b0;
  assign fwd_rs2_o = 1'b0;
`endif

  assign hit1      = d.use_rs1 & (d.rs1 != '0) & ~zero_v[d.rs1] & ~fwd_rs1_o;
  assign hit2      = d.use_rs2 & (d.rs2 != '0) & ~zero_v[d.rs2] & ~fwd_rs2_o;
  assign struct_hz = d.reg_write & (d.rd != '0) & full_v[d.rd];
  assign all_zero  = (cnt == '0);

  assign stall_o     = d.valid & ((state != S_RUN) | hit1 | hit2 | struct_hz | jump_i);
  assign issue_o     = d.valid & ~stall_o;
  assign flush_o     = (state == S_FLUSH);
  assign busy_mask_o = ~zero_v;

  // Control FSM: flush countdown after jumps, drain until scoreboard empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_RUN;
      fcnt         <= '0;
      drain_done_o <= 1'b0;
    end else begin
      drain_done_o <= 1'b0;
      case (state)
        S_RUN: begin
          if (jump_i) begin
            state <= S_FLUSH;
            fcnt  <= FLUSH_CNT_W'(FLUSH_CYCLES);
          end else if (drain_req_i) begin
            state <= S_DRAIN;
          end
        end
        S_FLUSH: begin
          if (jump_i)                          fcnt  <= FLUSH_CNT_W'(FLUSH_CYCLES);
          else if (fcnt == FLUSH_CNT_W'(1))    state <= S_RUN;
          else                                 fcnt  <= fcnt - 1'b1;
        end
        S_DRAIN: begin
          if (jump_i) begin
            state <= S_FLUSH;
            fcnt  <= FLUSH_CNT_W'(FLUSH_CYCLES);
          end else if (all_zero) begin
            drain_done_o <= 1'b1;
            state        <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Sticky flag for a writeback with nothing in flight
  always_ff @(posedge clk) begin
    if (!rst_n)      wb_err_o <= 1'b0;
    else if (|unf_v) wb_err_o <= 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural model queues expected
// outputs each cycle; they are popped and compared once the DUT settles.
module tb_hazard_ctrl;

  localparam int NR   = 32;
  localparam int CW   = 2;
  localparam int FC   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic dec_valid, dec_use_rs1, dec_use_rs2, dec_reg_write;
  logic [4:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic jump, drain_req, wb_reg_write;
  logic stall, issue, flush, drain_done, wb_err, fwd1, fwd2;
  logic [NR-1:0] busy;

  always #5 clk = ~clk;

  hazard_ctrl #(.NUM_REGS(NR), .CNT_W(CW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_use_rs1_i(dec_use_rs1), .dec_use_rs2_i(dec_use_rs2),
    .dec_rd_i(dec_rd), .dec_reg_write_i(dec_reg_write),
    .jump_i(jump), .drain_req_i(drain_req),
    .wb_reg_write_i(wb_reg_write), .wb_rd_i(wb_rd),
    .stall_o(stall), .issue_o(issue), .flush_o(flush),
    .drain_done_o(drain_done), .busy_mask_o(busy), .wb_err_o(wb_err),
    .fwd_rs1_o(fwd1), .fwd_rs2_o(fwd2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   mcnt[NR];
  int   mst;      // 0 run, 1 flush, 2 drain
  int   mfl;
  bit   merr, mdone;
  logic e_issue;
  int   done_seen, flush_seen;

  function automatic bit mfwd(input logic [4:0] rs);
`ifdef HAZARD_FWD_EN
    return wb_reg_write && (wb_rd == rs) && (mcnt[rs] == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    foreach (mcnt[i]) mcnt[i] = 0;
    mst = 0; mfl = 0; merr = 0; mdone = 0;
  endtask

  task automatic model_step();
    bit allz, inc, dec;
    if (!rst_n) begin
      model_reset();
      return;
    end
    allz = 1;
    foreach (mcnt[i]) if (mcnt[i] != 0) allz = 0;
    for (int r = 1; r < NR; r++) begin
      inc = e_issue && dec_reg_write && (dec_rd == r);
      dec = wb_reg_write && (wb_rd == r);
      if (dec && mcnt[r] == 0) merr = 1;
      if (inc && !(dec && mcnt[r] > 0))       mcnt[r]++;
      else if (!inc && dec && mcnt[r] > 0)    mcnt[r]--;
    end
    mdone = 0;
    case (mst)
      0: if (jump) begin mst = 1; mfl = FC; end else if (drain_req) mst = 2;
      1: if (jump) mfl = FC; else if (mfl == 1) mst = 0; else mfl--;
      default: if (jump) begin mst = 1; mfl = FC; end
               else if (allz) begin mdone = 1; mst = 0; end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { int k; logic [31:0] v; } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] obs(input int k);
    case (k)
      0: return 32'(stall);
      1: return 32'(issue);
      2: return 32'(fwd1);
      3: return 32'(fwd2);
      4: return 32'(flush);
      5: return 32'(drain_done);
      6: return 32'(busy);
      default: return 32'(wb_err);
    endcase
  endfunction

  function automatic string tag_of(input int k);
    case (k)
      0: return "stall";
      1: return "issue";
      2: return "fwd_rs1";
      3: return "fwd_rs2";
      4: return "flush";
      5: return "drain_done";
      6: return "busy_mask";
      default: return "wb_err";
    endcase
  endfunction

  task automatic push(input int k, input logic [31:0] v);
    exp_t e;
    e.k = k; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_all();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag_of(e.k), obs(e.k), e.v);
    end
  endtask

  // One clock: inputs already driven (just after a posedge)
  task automatic cyc();
    bit h1, h2, st, stl;
    logic [31:0] bm;
    h1  = dec_use_rs1 && dec_rs1 != 0 && mcnt[dec_rs1] > 0 && !mfwd(dec_rs1);
    h2  = dec_use_rs2 && dec_rs2 != 0 && mcnt[dec_rs2] > 0 && !mfwd(dec_rs2);
    st  = dec_reg_write && dec_rd != 0 && mcnt[dec_rd] == MAXC;
    stl = dec_valid && (mst != 0 || h1 || h2 || st || jump);
    e_issue = dec_valid && !stl;
    push(0, 32'(stl));
    push(1, 32'(e_issue));
    push(2, 32'(mfwd(dec_rs1)));
    push(3, 32'(mfwd(dec_rs2)));
    @(negedge clk);
    pop_all();
    @(posedge clk);
    model_step();
    #1;
    bm = '0;
    for (int r = 1; r < NR; r++) bm[r] = (mcnt[r] != 0);
    push(4, 32'(mst == 1));
    push(5, 32'(mdone));
    push(6, bm);
    push(7, 32'(merr));
    pop_all();
    if (drain_done) done_seen++;
    if (flush)      flush_seen++;
  endtask

  task automatic idle();
    dec_valid = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; dec_reg_write = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    jump = 0; drain_req = 0; wb_reg_write = 0; wb_rd = 0;
  endtask

  task automatic wr(input logic [4:0] rd);
    idle(); dec_valid = 1; dec_reg_write = 1; dec_rd = rd;
  endtask

  task automatic rd1(input logic [4:0] rs);
    idle(); dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = rs;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_reg_write = 1; wb_rd = rd;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    @(posedge clk); #1;
    cyc(); cyc();
    rst_n = 1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_err", 32'(wb_err), 32'd0);
    chk("rst_done", 32'(drain_done), 32'd0);

    // RAW on x5: stall until writeback
    wr(5); cyc();
    chk("busy5_set", 32'(busy[5]), 32'd1);
    rd1(5); cyc(); cyc();
    rd1(5); wb(5); cyc();
    rd1(5); cyc();
    idle(); cyc();

    // Structural: three in flight on x7, fourth stalls
    wr(7); cyc(); cyc(); cyc();
    wr(7); cyc();
    chk("busy7_set", 32'(busy[7]), 32'd1);
    idle(); wb(7); cyc(); cyc(); cyc();
    chk("busy7_clr", 32'(busy[7]), 32'd0);
    idle(); cyc();

    // Single jump: flush exactly FLUSH_CYCLES
    flush_seen = 0;
    rd1(1); jump = 1; cyc();
    rd1(1); cyc(); cyc(); cyc(); cyc();
    chk("flush_len", 32'(flush_seen), 32'(FC));
    // Jump re-issued mid-flush
    flush_seen = 0;
    rd1(1); jump = 1; cyc();
    rd1(1); jump = 1; cyc();
    rd1(1); cyc(); cyc(); cyc(); cyc();
    chk("flush_ext", 32'(flush_seen), 32'(FC + 1));

    // Drain with x3, x9 in flight
    wr(3); cyc();
    wr(9); cyc();
    done_seen = 0;
    idle(); drain_req = 1; cyc();
    rd1(0); cyc();
    rd1(0); wb(3); cyc();
    rd1(0); cyc();
    rd1(0); wb(9); cyc();
    rd1(0); cyc(); cyc(); cyc();
    chk("done_once", 32'(done_seen), 32'd1);

    // Writeback error handling
    idle(); wb(0); cyc();
    chk("wb_x0_noerr", 32'(wb_err), 32'd0);
    idle(); wb(4); cyc();
    idle(); cyc();
    chk("wb_err_sticky", 32'(wb_err), 32'd1);

    // Simultaneous issue and writeback on x6
    wr(6); cyc();
    wr(6); wb(6); cyc();
    chk("busy6_hold", 32'(busy[6]), 32'd1);
    idle(); wb(6); cyc();

    // Reset mid-flush and mid-drain
    idle(); jump = 1; cyc();
    idle(); rst_n = 0; cyc();
    rst_n = 1; chk("rst_flush2", 32'(flush), 32'd0);
    wr(2); cyc();
    idle(); drain_req = 1; cyc();
    idle(); rst_n = 0; cyc();
    rst_n = 1; chk("rst_err2", 32'(wb_err), 32'd0);
    idle(); cyc();

    // Random traffic on a small register window
    for (int i = 0; i < 400; i++) begin
      dec_valid     = ($urandom_range(0, 3) != 0);
      dec_rs1       = 5'($urandom_range(0, 3));
      dec_rs2       = 5'($urandom_range(0, 3));
      dec_use_rs1   = $urandom_range(0, 1);
      dec_use_rs2   = $urandom_range(0, 1);
      dec_rd        = 5'($urandom_range(0, 3));
      dec_reg_write = $urandom_range(0, 1);
      jump          = ($urandom_range(0, 11) == 0);
      drain_req     = ($urandom_range(0, 13) == 0);
      wb_reg_write  = $urandom_range(0, 1);
      wb_rd         = 5'($urandom_range(0, 3));
      rst_n         = ($urandom_range(0, 79) != 0);
      cyc();
    end
    rst_n = 1;
    idle(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
